// File: rtl/tmds_channel_decoder.sv
// -----------------------------------------------------------------------------
// tmds_channel_decoder
//
// Receive-side decoder for one TMDS channel, running in the pixel clock domain
// after a 10:1 deserializer. Finds the 10-bit symbol boundary by bit-slipping
// until control tokens line up, then decodes each aligned symbol into an 8-bit
// video byte or a 2-bit control code with a data-enable flag.
//
// Pipeline: stage 1 registers the aligned window, stage 2 registers the decode.
//
// Ports:
//   pixclk    in   1   pixel clock, one 10-bit word per cycle
//   rst       in   1   synchronous active-high reset
//   raw_word  in  10   deserialized word, bit 0 is the earliest serial bit
//   data      out  8   decoded video byte
//   ctrl      out  2   decoded control code {C1,C0}
//   de        out  1   1 = data period, 0 = control period
//   locked    out  1   symbol alignment established
//   offset    out  4   current bit-slip offset, 0..9
//   loss_cnt  out  8   saturating count of lock losses (TMDS_DEC_LOSSCNT_EN only)
//
// Optional feature macro: TMDS_DEC_LOSSCNT_EN
// -----------------------------------------------------------------------------
module tmds_channel_decoder #(
    parameter int unsigned LOCK_RUN   = 8,
    parameter int unsigned SEARCH_WIN = 64,
    parameter int unsigned LOSS_WIN   = 4096
) (
    input  logic       pixclk,
    input  logic       rst,
    input  logic [9:0] raw_word,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] offset
`ifdef TMDS_DEC_LOSSCNT_EN
    ,
    output logic [7:0] loss_cnt
`endif
);

    localparam int unsigned QMAX = (SEARCH_WIN > LOSS_WIN) ? SEARCH_WIN : LOSS_WIN;
    localparam int unsigned QW   = $clog2(QMAX + 1);
    localparam int unsigned RW   = $clog2(LOCK_RUN + 1);

    typedef enum logic [0:0] {StSearch, StLocked} state_e;

    state_e        state;
    logic [9:0]    prev_word;
    logic [9:0]    win;
    logic [RW-1:0] run_cnt;
    logic [QW-1:0] quiet_cnt;

    logic [9:0]    win_nxt;
    logic          tok_hit;
    logic [1:0]    tok_code;
    logic [RW-1:0] run_nxt;
    logic [QW-1:0] quiet_nxt;
    logic          lock_now;
    logic          loss_now;
    logic          slip_now;
    logic          locked_nxt;
    logic [7:0]    m;
    logic [7:0]    dec_data;

    // Window selection and stage-1 token / data decode.
    always_comb begin
        // Two consecutive words form a 20-bit serial span; offset picks the symbol.
        win_nxt = 10'({raw_word, prev_word} >> offset);

        tok_hit  = 1'b1;
        tok_code = 2'b00;
        unique case (win)
            10'b1101010100: tok_code = 2'b00;
            10'b0010101011: tok_code = 2'b01;
            10'b0101010100: tok_code = 2'b10;
            10'b1010101011: tok_code = 2'b11;
            default:        tok_hit  = 1'b0;
        endcase

        m           = win[9] ? ~win[7:0] : win[7:0];
        dec_data    = 8'h00;
        dec_data[0] = m[0];
        for (int i = 1; i < 8; i++) begin
            dec_data[i] = win[8] ? (m[i] ^ m[i-1]) : ~(m[i] ^ m[i-1]);
        end

        run_nxt   = run_cnt + 1'b1;
        quiet_nxt = quiet_cnt + 1'b1;

        lock_now   = (state == StSearch) && tok_hit && (run_nxt == RW'(LOCK_RUN));
        loss_now   = (state == StLocked) && !tok_hit && (quiet_nxt == QW'(LOSS_WIN));
        slip_now   = (state == StSearch) && !tok_hit && (quiet_nxt == QW'(SEARCH_WIN));
        // Output gating follows the lock state this edge is about to enter.
        locked_nxt = lock_now || ((state == StLocked) && !loss_now);
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            state     <= StSearch;
            prev_word <= 10'd0;
            win       <= 10'd0;
            run_cnt   <= '0;
            quiet_cnt <= '0;
            offset    <= 4'd0;
            locked    <= 1'b0;
            data      <= 8'h00;
            ctrl      <= 2'b00;
            de        <= 1'b0;
`ifdef TMDS_DEC_LOSSCNT_EN
            loss_cnt  <= 8'h00;
`endif
        end else begin
            prev_word <= raw_word;
            win       <= win_nxt;
            locked    <= locked_nxt;

            if (!locked_nxt) begin
                data <= 8'h00;
                ctrl <= 2'b00;
                de   <= 1'b0;
            end else if (tok_hit) begin
                data <= 8'h00;
                ctrl <= tok_code;
                de   <= 1'b0;
            end else begin
                // ctrl keeps the last control code through the data period
                data <= dec_data;
                de   <= 1'b1;
            end

            unique case (state)
                StSearch: begin
                    if (tok_hit) begin
                        quiet_cnt <= '0;
                        if (lock_now) begin
                            state   <= StLocked;
                            run_cnt <= '0;
                        end else begin
                            run_cnt <= run_nxt;
                        end
                    end else begin
                        run_cnt <= '0;
                        if (slip_now) begin
                            quiet_cnt <= '0;
                            offset    <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                        end else begin
                            quiet_cnt <= quiet_nxt;
                        end
                    end
                end
                StLocked: begin
                    if (tok_hit) begin
                        quiet_cnt <= '0;
                    end else if (loss_now) begin
                        // offset is kept so re-lock is tried at the same alignment first
                        state     <= StSearch;
                        quiet_cnt <= '0;
                        run_cnt   <= '0;
`ifdef TMDS_DEC_LOSSCNT_EN
                        if (loss_cnt != 8'hFF) begin
                            loss_cnt <= loss_cnt + 8'd1;
                        end
`endif
                    end else begin
                        quiet_cnt <= quiet_nxt;
                    end
                end
                default: state <= StSearch;
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_channel_decoder
//
// Self-checking bench for tmds_channel_decoder. A reference model works on a
// serial bit stream and integer arithmetic; every cycle the DUT outputs are
// compared against it, alongside table vectors and explicit corner checks.
// -----------------------------------------------------------------------------
module tb_tmds_channel_decoder;

    localparam int LOCK_RUN   = 8;
    localparam int SEARCH_WIN = 64;
    localparam int LOSS_WIN   = 4096;

    localparam logic [9:0] TOK00  = 10'b1101010100;
    localparam logic [9:0] DATA_W = 10'b0100000000;

    logic       pixclk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] raw_word = 10'd0;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] offset;
`ifdef TMDS_DEC_LOSSCNT_EN
    logic [7:0] loss_cnt;
`endif

    always #5 pixclk = ~pixclk;

    tmds_channel_decoder dut (
        .pixclk   (pixclk),
        .rst      (rst),
        .raw_word (raw_word),
        .data     (data),
        .ctrl     (ctrl),
        .de       (de),
        .locked   (locked),
        .offset   (offset)
`ifdef TMDS_DEC_LOSSCNT_EN
        ,
        .loss_cnt (loss_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, all plain integers.
    int m_prev, m_win, m_off, m_run, m_quiet, m_data, m_ctrl, m_de, m_lossn;
    bit m_locked;

    bit bitq[$];
    int enc_disp;

    logic [9:0] toks [4] = '{10'b1101010100, 10'b0010101011,
                             10'b0101010100, 10'b1010101011};

    typedef struct {
        logic [9:0] raw;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       de;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tok_code(input int w);
        case (w)
            10'b1101010100: return 0;
            10'b0010101011: return 1;
            10'b0101010100: return 2;
            10'b1010101011: return 3;
            default:        return -1;
        endcase
    endfunction

    // Undo the XOR/XNOR chain: d = m ^ (m << 1), bits 7:1 inverted for XNOR.
    function automatic int tmds_decode(input int sym);
        int mm;
        int d;
        mm = sym & 255;
        if ((sym & 512) != 0) mm = mm ^ 255;
        d = (mm ^ (mm << 1)) & 255;
        if ((sym & 256) == 0) d = d ^ 8'hFE;
        return d;
    endfunction

    task automatic model_step(input int w, input bit r);
        int code;
        int nxt_win;
        if (r) begin
            m_prev = 0; m_win = 0; m_off = 0; m_run = 0; m_quiet = 0;
            m_data = 0; m_ctrl = 0; m_de = 0; m_locked = 0; m_lossn = 0;
            return;
        end
        code    = tok_code(m_win);
        nxt_win = (((w << 10) | m_prev) >> m_off) & 1023;
        if (!m_locked) begin
            if (code >= 0) begin
                m_quiet = 0;
                m_run++;
                if (m_run == LOCK_RUN) begin
                    m_locked = 1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
                m_quiet++;
                if (m_quiet == SEARCH_WIN) begin
                    m_quiet = 0;
                    m_off = (m_off + 1) % 10;
                end
            end
        end else begin
            if (code >= 0) m_quiet = 0;
            else begin
                m_quiet++;
                if (m_quiet == LOSS_WIN) begin
                    m_locked = 0;
                    m_quiet = 0;
                    m_run = 0;
                    if (m_lossn < 255) m_lossn++;
                end
            end
        end
        if (!m_locked) begin
            m_data = 0; m_ctrl = 0; m_de = 0;
        end else if (code >= 0) begin
            m_data = 0; m_ctrl = code; m_de = 0;
        end else begin
            m_data = tmds_decode(m_win); m_de = 1;
        end
        m_win  = nxt_win;
        m_prev = w;
    endtask

    task automatic check_model();
        chk("model data",   int'(data),   m_data);
        chk("model ctrl",   int'(ctrl),   m_ctrl);
        chk("model de",     int'(de),     m_de);
        chk("model locked", int'(locked), int'(m_locked));
        chk("model offset", int'(offset), m_off);
`ifdef TMDS_DEC_LOSSCNT_EN
        chk("model loss_cnt", int'(loss_cnt), m_lossn);
`endif
    endtask

    task automatic cycle(input logic [9:0] w, input bit r);
        raw_word = w;
        rst = r;
        @(posedge pixclk);
        model_step(int'(w), r);
        #1;
        check_model();
    endtask

    task automatic push_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) bitq.push_back(s[i]);
    endtask

    // Pad the serial stream so the next symbol starts p bits into a word.
    task automatic set_phase(input int p);
        int r;
        int n;
        r = bitq.size();
        n = (p >= r) ? p - r : p + 10 - r;
        for (int i = 0; i < n; i++) bitq.push_back(1'b0);
    endtask

    task automatic send(input logic [9:0] s, input int n);
        logic [9:0] w;
        for (int k = 0; k < n; k++) begin
            while (bitq.size() < 10) push_sym(s);
            for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
            cycle(w, 1'b0);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(10'($urandom), 1'b1);
        bitq.delete();
    endtask

    // Reference DVI encoder with running disparity.
    task automatic encode(input logic [7:0] d, output logic [9:0] q);
        logic [8:0] qm;
        int n1, n1q, n0q;
        n1 = $countones(d);
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_disp == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            enc_disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((enc_disp > 0 && n1q > n0q) || (enc_disp < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            enc_disp += (qm[8] ? 2 : 0) + (n0q - n1q);
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            enc_disp += (qm[8] ? 0 : -2) + (n1q - n0q);
        end
    endtask

    initial begin
        logic [9:0] sym;
        logic [7:0] sweep_exp[256];

        vecs[0]  = '{10'b1101010100, 8'h00, 2'd0, 1'b0};
        vecs[1]  = '{10'b0010101011, 8'h00, 2'd1, 1'b0};
        vecs[2]  = '{10'b0101010100, 8'h00, 2'd2, 1'b0};
        vecs[3]  = '{10'b1010101011, 8'h00, 2'd3, 1'b0};
        vecs[4]  = '{10'b0100000000, 8'h00, 2'd3, 1'b1};
        vecs[5]  = '{10'b1000000000, 8'hFF, 2'd3, 1'b1};
        vecs[6]  = '{10'b1101010100, 8'h00, 2'd0, 1'b0};
        vecs[7]  = '{10'b0111111111, 8'h01, 2'd0, 1'b1};
        vecs[8]  = '{10'b0001010101, 8'h01, 2'd0, 1'b1};
        vecs[9]  = '{10'b0011111111, 8'hFF, 2'd0, 1'b1};
        vecs[10] = '{10'b0010101011, 8'h00, 2'd1, 1'b0};
        vecs[11] = '{10'b1101010100, 8'h00, 2'd0, 1'b0};

        // Reset with random input.
        do_reset(3);
        chk("reset data",   int'(data),   0);
        chk("reset ctrl",   int'(ctrl),   0);
        chk("reset de",     int'(de),     0);
        chk("reset locked", int'(locked), 0);
        chk("reset offset", int'(offset), 0);

        // Aligned lock: the 10th word after reset outputs the 8th token.
        set_phase(0);
        for (int i = 0; i < 10; i++) begin
            send(TOK00, 1);
            chk("lock edge", int'(locked), (i == 9) ? 1 : 0);
        end
        chk("lock de",   int'(de),   0);
        chk("lock ctrl", int'(ctrl), 0);

        // Table vectors, two-cycle latency.
        for (int j = 0; j < 14; j++) begin
            send((j < 12) ? vecs[j].raw : TOK00, 1);
            if (j >= 2) begin
                chk("vec data", int'(data), int'(vecs[j-2].data));
                chk("vec ctrl", int'(ctrl), int'(vecs[j-2].ctrl));
                chk("vec de",   int'(de),   int'(vecs[j-2].de));
            end
        end

        // Decode sweep of all encoder outputs.
        enc_disp = 0;
        for (int j = 0; j < 258; j++) begin
            if (j < 256) begin
                encode(8'(j), sym);
                sweep_exp[j] = 8'(j);
                send(sym, 1);
            end else begin
                send(TOK00, 1);
            end
            if (j >= 2) begin
                chk("sweep data", int'(data), int'(sweep_exp[j-2]));
                chk("sweep de",   int'(de),   1);
            end
        end

        // Slip search: stream delayed by 3 bits.
        do_reset(1);
        set_phase(3);
        send(TOK00, 3 * SEARCH_WIN + 30);
        chk("slip offset", int'(offset), 3);
        chk("slip locked", int'(locked), 1);

        // Reset while locked.
        cycle(10'($urandom), 1'b1);
        chk("midreset locked", int'(locked), 0);
        chk("midreset offset", int'(offset), 0);
        chk("midreset de",     int'(de),     0);
        bitq.delete();

        // Lock at offset 9, then loss and re-lock at the same offset.
        set_phase(9);
        send(TOK00, 9 * SEARCH_WIN + 30);
        chk("off9 offset", int'(offset), 9);
        chk("off9 locked", int'(locked), 1);
        send(DATA_W, LOSS_WIN);
        chk("loss hold", int'(locked), 1);
        send(DATA_W, 2);
        chk("loss locked", int'(locked), 0);
        chk("loss offset", int'(offset), 9);
        chk("loss de",     int'(de),     0);
        chk("loss data",   int'(data),   0);
        send(TOK00, 12);
        chk("relock locked", int'(locked), 1);
        chk("relock offset", int'(offset), 9);

        // Wrap: lose lock at 9, realign stream to 0, slip 9 -> 0.
        send(DATA_W, LOSS_WIN + 2);
        chk("wrap unlocked", int'(locked), 0);
        set_phase(0);
        send(TOK00, SEARCH_WIN + 30);
        chk("wrap offset", int'(offset), 0);
        chk("wrap locked", int'(locked), 1);
`ifdef TMDS_DEC_LOSSCNT_EN
        chk("loss_cnt", int'(loss_cnt), 2);
`endif

        // Random words and tokens with occasional reset.
        do_reset(1);
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(2) == 0) ? 10'($urandom) : toks[$urandom_range(3)],
                  ($urandom_range(199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
